dot_product_128_accum: RTL

//  Downstream consumer of the 128x1 eight-lane address counter. Each beat takes 8 element pairs
//  (matrix-row element, vector element) read at addresses base+0..base+7.

---
 rtl/dot_product_128_accum.sv | 78 +++++++
 1 files changed

// File: rtl/dot_product_128_accum.sv
// dot_product_128_accum: 8-lane signed multiply, registered adder tree, 16-beat accumulate
// into one 128-element dot product, with a valid/ready result port.
module dot_product_128_accum #(
    parameter int DATA_W = 8,
    parameter int LANES  = 8,
    parameter int BEATS  = 16,
    parameter int ACC_W  = 24
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      in_valid,
    input  logic [LANES*DATA_W-1:0]   a_data,
    input  logic [LANES*DATA_W-1:0]   b_data,
    output logic                      busy,
    output logic [3:0]                beat_idx,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ACC_W-1:0]          out_data
);
    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;
    state_t state;
    logic signed [2*DATA_W-1:0] p [LANES];
    logic signed [ACC_W-1:0] s, acc, sum;
    logic v1, v2, accept;
    assign accept = state == ACCUM && in_valid;
    always_comb begin
        sum = '0;
        for (int j = 0; j < LANES; j++) sum = sum + ACC_W'(p[j]);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            beat_idx  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            s         <= '0;
            acc       <= '0;
            for (int j = 0; j < LANES; j++) p[j] <= '0;
        end else begin
            v1 <= accept;
            v2 <= v1;
            if (accept)
                for (int j = 0; j < LANES; j++)
                    p[j] <= (2*DATA_W)'($signed(a_data[j*DATA_W +: DATA_W])) *
                            (2*DATA_W)'($signed(b_data[j*DATA_W +: DATA_W]));
            if (v1) s <= sum;
            if (state == IDLE && start) acc <= '0;
            else if (v2) acc <= acc + s;
            case (state)
                IDLE: if (start) begin
                    state    <= ACCUM;
                    busy     <= 1'b1;
                    beat_idx <= '0;
                end
                ACCUM: if (in_valid) begin
                    beat_idx <= beat_idx + 4'd1;
                    if (beat_idx == 4'(BEATS-1)) state <= DRAIN;
                end
                // the final beat's partial sum is in s exactly when stage 1 has emptied
                DRAIN: if (v2 && !v1) begin
                    out_data  <= acc + s;
                    out_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: if (out_ready) begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
